// File: rtl/arp_cache_query_arb.sv
// Round-robin arbiter sharing one ARP cache query port among PORTS requesters.
// An in-order tag FIFO remembers who asked, so each in-order cache response is routed back.
module arp_cache_query_arb #(
  parameter int PORTS          = 4,
  parameter int TAG_FIFO_DEPTH = 4,
  localparam int ID_W          = $clog2(PORTS),
  localparam int CW            = $clog2(TAG_FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORTS-1:0]      s_query_request_valid,
  output logic [PORTS-1:0]      s_query_request_ready,
  input  logic [PORTS*32-1:0]   s_query_request_ip,
  output logic [PORTS-1:0]      s_query_response_valid,
  input  logic [PORTS-1:0]      s_query_response_ready,
  output logic [PORTS-1:0]      s_query_response_error,
  output logic [PORTS*48-1:0]   s_query_response_mac,
  output logic                  m_query_request_valid,
  input  logic                  m_query_request_ready,
  output logic [31:0]           m_query_request_ip,
  input  logic                  m_query_response_valid,
  output logic                  m_query_response_ready,
  input  logic                  m_query_response_error,
  input  logic [47:0]           m_query_response_mac,
  output logic [CW-1:0]         outstanding,
  output logic                  orphan_response
);

  localparam int AW = CW - 1;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] lock_grant;
  logic            lock_reg;
  logic [ID_W-1:0] rr_grant;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] head;
  logic [ID_W-1:0] search_idx;
  logic            search_found;
  logic [ID_W-1:0] tag_mem [TAG_FIFO_DEPTH];
  logic [CW-1:0]   wr_ptr;
  logic [CW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  function automatic logic [ID_W-1:0] next_port(input logic [ID_W-1:0] p);
    return (p == ID_W'(PORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search: first valid port at or after rr_ptr, wrapping modulo PORTS
  always_comb begin
    rr_grant     = rr_ptr;
    search_found = 1'b0;
    search_idx   = rr_ptr;
    for (int k = 0; k < PORTS; k++) begin
      if (!search_found && s_query_request_valid[search_idx]) begin
        rr_grant     = search_idx;
        search_found = 1'b1;
      end
      search_idx = next_port(search_idx);
    end
  end

  assign grant      = lock_reg ? lock_grant : rr_grant;
  assign fifo_full  = (count == CW'(TAG_FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign head       = tag_mem[rd_ptr[AW-1:0]];

  always_comb begin
    m_query_request_ip = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (ID_W'(i) == grant) m_query_request_ip = s_query_request_ip[32*i +: 32];
    end
  end

  assign m_query_request_valid  = !fifo_full && s_query_request_valid[grant];
  assign s_query_request_ready  = (m_query_request_ready && !fifo_full) ?
                                  (PORTS'(1) << grant) : '0;

  // Responses follow the tag at the FIFO head; an empty FIFO swallows strays
  assign s_query_response_valid = (m_query_response_valid && !fifo_empty) ?
                                  (PORTS'(1) << head) : '0;
  assign m_query_response_ready = fifo_empty ? 1'b1 : s_query_response_ready[head];
  assign s_query_response_error = {PORTS{m_query_response_error}};
  assign s_query_response_mac   = {PORTS{m_query_response_mac}};

  assign push        = m_query_request_valid && m_query_request_ready;
  assign pop         = m_query_response_valid && m_query_response_ready && !fifo_empty;
  assign outstanding = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      rr_ptr          <= '0;
      lock_reg        <= 1'b0;
      orphan_response <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= next_port(grant);
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push) lock_reg <= 1'b0;
      else if (m_query_request_valid) lock_reg <= 1'b1;
      orphan_response <= m_query_response_valid && fifo_empty;
    end
  end

  // Tag storage and held grant carry no reset; control qualifies their use
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr[AW-1:0]] <= grant;
    if (m_query_request_valid && !m_query_request_ready) lock_grant <= grant;
  end

endmodule

// File: tb/tb_arp_cache_query_arb.sv
// Bench for arp_cache_query_arb: directed scenarios with literal expectations, then
// randomized traffic against a queue-based model of issued queries.
module tb_arp_cache_query_arb;
  localparam int P = 4;
  localparam int D = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [P-1:0]    s_req_valid, s_req_ready, s_resp_valid, s_resp_ready, s_resp_error;
  logic [P*32-1:0] s_req_ip;
  logic [P*48-1:0] s_resp_mac;
  logic            m_req_valid, m_req_ready, m_resp_valid, m_resp_ready, m_resp_error;
  logic [31:0]     m_req_ip;
  logic [47:0]     m_resp_mac;
  logic [2:0]      outstanding;
  logic            orphan;

  always #5 clk = ~clk;

  arp_cache_query_arb #(.PORTS(P), .TAG_FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .s_query_request_valid(s_req_valid), .s_query_request_ready(s_req_ready),
    .s_query_request_ip(s_req_ip),
    .s_query_response_valid(s_resp_valid), .s_query_response_ready(s_resp_ready),
    .s_query_response_error(s_resp_error), .s_query_response_mac(s_resp_mac),
    .m_query_request_valid(m_req_valid), .m_query_request_ready(m_req_ready),
    .m_query_request_ip(m_req_ip),
    .m_query_response_valid(m_resp_valid), .m_query_response_ready(m_resp_ready),
    .m_query_response_error(m_resp_error), .m_query_response_mac(m_resp_mac),
    .outstanding(outstanding), .orphan_response(orphan)
  );

  typedef struct { int port; logic [31:0] ip; } iss_t;

  // Model: queries issued but not yet answered, in issue order
  iss_t        issq[$];
  int          rr = 0;
  int          lock_port = 0;
  bit          locked = 0;
  bit          orphan_exp = 0;
  bit          rand_mode = 0;
  bit          cv_done = 0;
  bit          pend [P];
  logic [31:0] pip [P];
  int          total = 0;
  int          bad = 0;

  function automatic logic [47:0] fmac(input logic [31:0] ip);
    return {ip ^ 32'h5A5A_5A5A, ip[15:0] + 16'h1111};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, want);
    end
  endtask

  function automatic int exp_grant();
    if (locked) return lock_port;
    for (int k = 0; k < P; k++) begin
      if (s_req_valid[(rr + k) % P]) return (rr + k) % P;
    end
    return rr;
  endfunction

  task automatic compare_update();
    int g, h;
    bit full, empty, mv, mrr, push, pop;
    logic [P-1:0] erdy, evld;
    full  = (issq.size() == D);
    empty = (issq.size() == 0);
    g     = exp_grant();
    mv    = !full && s_req_valid[g];
    erdy  = '0;
    if (!full && m_req_ready) erdy[g] = 1'b1;
    h     = empty ? 0 : issq[0].port;
    evld  = '0;
    if (m_resp_valid && !empty) evld[h] = 1'b1;
    mrr   = empty ? 1'b1 : s_resp_ready[h];
    chk("m_req_valid", m_req_valid, mv);
    chk("m_req_ip", m_req_ip, s_req_ip[32*g +: 32]);
    chk("s_req_ready", s_req_ready, erdy);
    chk("s_resp_valid", s_resp_valid, evld);
    chk("m_resp_ready", m_resp_ready, mrr);
    chk("outstanding", outstanding, issq.size());
    chk("orphan", orphan, orphan_exp);
    for (int p = 0; p < P; p++) begin
      chk("resp_mac_bcast", s_resp_mac[48*p +: 48], m_resp_mac);
      chk("resp_err_bcast", s_resp_error[p], m_resp_error);
    end
    if (rand_mode && m_resp_valid && mrr && !empty) begin
      chk("e2e_mac", s_resp_mac[48*h +: 48], fmac(issq[0].ip));
      chk("e2e_err", s_resp_error[h], ^issq[0].ip);
    end
    orphan_exp = m_resp_valid && empty;
    push = mv && m_req_ready;
    pop  = m_resp_valid && mrr && !empty;
    if (pop) begin
      void'(issq.pop_front());
      cv_done = 1'b1;
    end
    if (push) begin
      issq.push_back('{port: g, ip: s_req_ip[32*g +: 32]});
      rr      = (g + 1) % P;
      locked  = 1'b0;
      pend[g] = 1'b0;
    end else if (mv) begin
      locked    = 1'b1;
      lock_port = g;
    end
    if (rst) begin
      issq.delete();
      rr = 0; locked = 0; orphan_exp = 0; cv_done = 0;
      for (int p = 0; p < P; p++) pend[p] = 1'b0;
    end
  endtask

  task automatic go_neg();
    @(negedge clk);
    compare_update();
  endtask

  task automatic go_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_req_valid  = '0;
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b0;
    s_resp_ready = '1;
    m_resp_error = 1'b0;
    m_resp_mac   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    go_neg();
    go_pos();
    rst = 1'b0;
  endtask

  task automatic rand_drive();
    for (int p = 0; p < P; p++) begin
      if (!pend[p] && $urandom_range(3) == 0) begin
        pend[p] = 1'b1;
        pip[p]  = $urandom;
      end
      s_req_valid[p]        = pend[p];
      s_req_ip[32*p +: 32]  = pip[p];
      s_resp_ready[p]       = ($urandom_range(3) != 0);
    end
    m_req_ready = ($urandom_range(2) != 0);
    if (cv_done) begin
      m_resp_valid = 1'b0;
      cv_done      = 1'b0;
    end
    if (!m_resp_valid && issq.size() > 0 && $urandom_range(1) == 1) begin
      m_resp_valid = 1'b1;
      m_resp_mac   = fmac(issq[0].ip);
      m_resp_error = ^issq[0].ip;
    end
  endtask

  initial begin
    logic [3:0] e;
    rst = 1'b1;
    s_req_ip = '0;
    for (int p = 0; p < P; p++) begin pend[p] = 1'b0; pip[p] = '0; end
    idle();
    do_reset();

    // reset state
    go_neg();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_m_resp_ready", m_resp_ready, 1);
    chk("rst_s_req_ready", s_req_ready, 0);
    chk("rst_s_resp_valid", s_resp_valid, 0);
    go_pos();

    // single request on port 2
    do_reset();
    s_req_valid = 4'b0100;
    s_req_ip[64 +: 32] = 32'hC0A8_0001;
    m_req_ready = 1'b1;
    go_neg();
    chk("single_ip", m_req_ip, 32'hC0A8_0001);
    chk("single_rdy", s_req_ready, 4'b0100);
    chk("single_out0", outstanding, 0);
    go_pos();
    s_req_valid = '0;
    m_resp_valid = 1'b1;
    m_resp_mac = 48'h0102_0304_0506;
    go_neg();
    chk("single_resp_vld", s_resp_valid, 4'b0100);
    chk("single_resp_mac", s_resp_mac[96 +: 48], 48'h0102_0304_0506);
    chk("single_out1", outstanding, 1);
    go_pos();
    m_resp_valid = 1'b0;
    go_neg();
    chk("single_out2", outstanding, 0);
    go_pos();

    // round-robin fairness with responses in the same order
    do_reset();
    m_req_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      s_req_valid  = (k < 6) ? 4'hF : 4'h0;
      m_resp_valid = (k >= 1);
      go_neg();
      if (k < 6) begin
        e = 4'b0001 << (k % 4);
        chk("rr_grant", s_req_ready, e);
      end
      if (k >= 1) begin
        e = 4'b0001 << ((k - 1) % 4);
        chk("rr_resp", s_resp_valid, e);
      end
      go_pos();
    end
    idle();

    // lock holds grant on port 1 through stall and a dropped valid
    do_reset();
    s_req_valid = 4'b1010;
    s_req_ip[32 +: 32] = 32'h0A00_0001;
    s_req_ip[96 +: 32] = 32'h0A00_0003;
    for (int k = 0; k < 3; k++) begin
      go_neg();
      chk("lock_vld", m_req_valid, 1);
      chk("lock_ip", m_req_ip, 32'h0A00_0001);
      go_pos();
    end
    s_req_valid = 4'b1000;
    go_neg();
    chk("lock_drop_ip", m_req_ip, 32'h0A00_0001);
    chk("lock_drop_vld", m_req_valid, 0);
    go_pos();
    s_req_valid = 4'b1010;
    m_req_ready = 1'b1;
    go_neg();
    chk("lock_hs", s_req_ready, 4'b0010);
    go_pos();
    go_neg();
    chk("lock_next", s_req_ready, 4'b1000);
    chk("lock_next_ip", m_req_ip, 32'h0A00_0003);
    go_pos();
    idle();

    // FIFO full blocks even on the popping cycle
    do_reset();
    s_req_valid = 4'b0001;
    s_req_ip[0 +: 32] = 32'h0102_0304;
    m_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin go_neg(); go_pos(); end
    go_neg();
    chk("full_rdy", s_req_ready, 0);
    chk("full_out", outstanding, 4);
    go_pos();
    m_resp_valid = 1'b1;
    go_neg();
    chk("full_pop_rdy", s_req_ready, 0);
    chk("full_pop_resp", s_resp_valid, 4'b0001);
    go_pos();
    m_resp_valid = 1'b0;
    go_neg();
    chk("full_after_rdy", s_req_ready, 4'b0001);
    chk("full_after_out", outstanding, 3);
    go_pos();
    idle();

    // head-of-line response backpressure
    do_reset();
    s_req_valid = 4'b0011;
    m_req_ready = 1'b1;
    go_neg(); chk("bp_g0", s_req_ready, 4'b0001); go_pos();
    go_neg(); chk("bp_g1", s_req_ready, 4'b0010); go_pos();
    s_req_valid  = '0;
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b1;
    s_resp_ready = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      go_neg();
      chk("bp_mrdy", m_resp_ready, 0);
      chk("bp_vld", s_resp_valid, 4'b0001);
      go_pos();
    end
    s_resp_ready = 4'hF;
    go_neg(); chk("bp_release", m_resp_ready, 1); go_pos();
    go_neg(); chk("bp_next", s_resp_valid, 4'b0010); go_pos();
    idle();

    // orphan response, then reset with queries outstanding
    do_reset();
    m_resp_valid = 1'b1;
    go_neg();
    chk("orph_mrdy", m_resp_ready, 1);
    chk("orph_svld", s_resp_valid, 0);
    go_pos();
    m_resp_valid = 1'b0;
    go_neg(); chk("orph_pulse", orphan, 1); go_pos();
    go_neg(); chk("orph_clear", orphan, 0); go_pos();
    s_req_valid = 4'b0111;
    m_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin go_neg(); go_pos(); end
    idle();
    go_neg(); chk("pre_rst_out", outstanding, 3); go_pos();
    do_reset();
    go_neg();
    chk("post_rst_out", outstanding, 0);
    chk("post_rst_svld", s_resp_valid, 0);
    chk("post_rst_srdy", s_req_ready, 0);
    chk("post_rst_mrdy", m_resp_ready, 1);
    go_pos();

    // randomized traffic
    do_reset();
    rand_mode = 1'b1;
    cv_done   = 1'b0;
    repeat (3000) begin
      rand_drive();
      go_neg();
      go_pos();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arp_cache_query_arb.md
Name: arp_cache_query_arb

Overview:
- Shares the single query port of the ARP cache among PORTS independent requesters, e.g. several IP TX paths.
- Arbitrates requests round-robin and records the winner's index in an in-order tag FIFO.
- Routes each cache response back to the requester that issued it.
- Sits between the requester ports and the cache query/response port. The cache answers queries strictly in order, which the tag FIFO relies on.

Parameters:
PORTS, 4, number of requester ports (2..16)
TAG_FIFO_DEPTH, 4, max outstanding queries; power of two, >=2
ID_W, $clog2(PORTS), local: tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_query_request_valid  in  PORTS  per-port request valid
s_query_request_ready  out  PORTS  per-port request ready
s_query_request_ip  in  PORTS*32  per-port IP, port i at [32*i+:32]
s_query_response_valid  out  PORTS  per-port response valid
s_query_response_ready  in  PORTS  per-port response ready
s_query_response_error  out  PORTS  per-port miss flag
s_query_response_mac  out  PORTS*48  per-port MAC, port i at [48*i+:48]
m_query_request_valid  out  1  to cache
m_query_request_ready  in  1  from cache
m_query_request_ip  out  32  to cache
m_query_response_valid  in  1  from cache
m_query_response_ready  out  1  to cache
m_query_response_error  in  1  from cache
m_query_response_mac  in  48  from cache
outstanding  out  ID_W+1.. $clog2(TAG_FIFO_DEPTH)+1  queries issued, response not yet taken
orphan_response  out  1  one-cycle pulse: cache response arrived with tag FIFO empty

Behaviour:
- Request path is combinational pass-through; zero added latency.
- m_query_request_valid = fifo_not_full & s_query_request_valid[grant].
- m_query_request_ip = s_query_request_ip[grant].
- s_query_request_ready[i] = (i==grant) & m_query_request_ready & fifo_not_full. All other ports see 0.
- Grant selection when unlocked: first valid port at or after rr_ptr, searching upward with wrap modulo PORTS. If no port is valid, grant = rr_ptr and m valid = 0.
- Lock: a cycle with m_query_request_valid=1 and m_query_request_ready=0 sets lock_reg and stores the grant. While locked, grant is held, so valid and IP stay stable until the handshake. Lock clears on the handshake.
- On request handshake:
  - push grant into the tag FIFO;
  - rr_ptr <= grant+1, wrapping PORTS-1 -> 0.
- Tag FIFO full blocks new requests even if a pop occurs in the same cycle. Simultaneous push and pop when not full leaves the count unchanged.
- Response path is combinational. head = tag at FIFO read pointer.
  - s_query_response_valid[head] = m_query_response_valid & fifo_not_empty; all other ports 0.
  - m_query_response_ready = fifo_not_empty ? s_query_response_ready[head] : 1.
  - error and mac are broadcast to every port's slice; only the head port's valid is asserted.
- Pop the tag FIFO on response handshake while non-empty.
- FIFO empty with m_query_response_valid=1: the response is accepted and dropped, and orphan_response pulses for 1 cycle.
- outstanding = FIFO count. It increments on push, decrements on pop, and is unchanged when both occur.
- Pointer and count widths are $clog2(TAG_FIFO_DEPTH)+1; full = count==TAG_FIFO_DEPTH.
- Reset:
  - FIFO pointers and count 0; rr_ptr 0; lock_reg 0; orphan_response 0.
  - All valid and ready outputs 0, except m_query_response_ready, which is 1 because the FIFO is empty.
  - Reset mid-transaction discards all tags. The cache must be reset with the same rst so that no stale responses arrive.
- Backpressure on one requester's response stalls all later responses; ordering is required and intentional.

Test Plan:
- Single request: port 2 queries 32'hC0A80001, cache returns mac 48'h0102_0304_0506 with error=0 one cycle later -> m_query_request_ip=C0A80001 in the same cycle; s_query_response_valid=4'b0100 with that mac; outstanding goes 0->1->0.
- Round-robin fairness: all 4 ports valid continuously, m_query_request_ready=1 -> grant sequence 0,1,2,3,0,1; responses are delivered in the same port order.
- Lock stability: ports 1 and 3 valid, m_query_request_ready=0 for 3 cycles, then port 1 drops valid -> the request stays on port 1 with a stable IP until the handshake (valid must not be dropped by a compliant source; the bench also checks the grant does not move).
- FIFO full: TAG_FIFO_DEPTH=4 with the cache holding responses -> the 5th request sees ready=0 and outstanding=4. The same cycle the first response pops, the request is still blocked; it is accepted the next cycle.
- Response backpressure: head port 0 holds s_query_response_ready=0 for 5 cycles -> m_query_response_ready=0 and port 1's queued response is not delivered until port 0 accepts.
- Orphan response and reset: inject m_query_response_valid with outstanding=0 -> m_query_response_ready=1 and orphan_response pulses once. Assert rst with 3 outstanding -> outstanding=0 and all s valid/ready=0 on the next cycle.
